aes_round_sequencer: RTL and testbench
======================================

# aes_round_sequencer

Controller for the shared single-round AES datapath. It arbitrates between an encrypt requester and a decrypt requester and latches the key size (128/192/256). It then sequences the datapath through load, middle rounds and final round, driving the round-key index into the precomputed key-expansion bus. It sits between the push-button/switch front end and the iterative cipher/decipher datapath, replacing free-running per-width round counters.

## Interface
Parameters:
- NR_128, 10, rounds for 128-bit key
- NR_192, 12, rounds for 192-bit key
- NR_256, 14, rounds for 256-bit key

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces IDLE immediately
- enc_req  in  1  encrypt request; level, held by requester until enc_gnt
- dec_req  in  1  decrypt request; level, held by requester until dec_gnt
- key_sel  in  2  00=128, 01=192, 10=256, 11=invalid; sampled only at acceptance
- enc_gnt  out  1  one-cycle pulse: encrypt request accepted
- dec_gnt  out  1  one-cycle pulse: decrypt request accepted
- busy  out  1  high from grant cycle through done cycle inclusive
- dp_load  out  1  datapath: load input block and AddRoundKey(rk_idx)
- dp_round  out  1  datapath: full round (enc or inverse) with rk_idx
- dp_final  out  1  datapath: final round (no (Inv)MixColumns) with rk_idx
- dp_decrypt  out  1  direction of the current operation, 1=decrypt
- rk_idx  out  4  round-key index into expansion bus, 0..14
- nr  out  4  latched round count of current operation
- done  out  1  one-cycle pulse: datapath output valid this cycle
- err  out  1  one-cycle pulse: request seen with key_sel=11, not accepted

## Operation
- States: IDLE, LOAD, ROUND, FINAL, DONE.
- IDLE: if (enc_req|dec_req) and key_sel!=11, arbitrate and go to LOAD. Latch nr from key_sel, dp_decrypt from the winner, and set last_winner.
- If a request is present with key_sel=11 in IDLE: err=1 for that cycle, stay IDLE. err repeats every cycle the condition holds.
- Arbitration: the two-requester round-robin. On a simultaneous request the side that did not win last time wins. last_winner resets to decrypt, so encrypt wins the first tie. A lone requester always wins.
- LOAD: enc_gnt or dec_gnt=1 and dp_load=1. rk_idx = 0 (encrypt) or nr (decrypt). Round counter r←1. Next state ROUND.
- ROUND: dp_round=1. rk_idx = r (encrypt) or nr−r (decrypt). r←r+1. When r==nr−1 the next state is FINAL. This gives exactly nr−1 ROUND cycles.
- FINAL: dp_final=1. rk_idx = nr (encrypt) or 0 (decrypt). Next state DONE.
- DONE: done=1 and rk_idx held. Next state IDLE.
- Requests and key_sel changes while busy are ignored. A held request is re-arbitrated in the IDLE cycle after DONE.
- dp_load, dp_round and dp_final are mutually exclusive and zero in IDLE and DONE.
- Width rules: r is 4 bits and never exceeds 13; nr−r is computed at 4 bits with no wrap.

## Timing
- Acceptance: a request sampled in IDLE at edge t puts LOAD (with grant) in cycle t+1.
- Cycle counts: LOAD 1 cycle, ROUND nr−1 cycles, FINAL 1 cycle, DONE 1 cycle.
- Latency: done is asserted nr+1 cycles after the LOAD cycle (11 / 13 / 15 for 128 / 192 / 256). busy lasts nr+2 cycles.
- Back-to-back: minimum one IDLE cycle between DONE and the next LOAD.
- Reset values: all outputs are 0 (nr=0, rk_idx=0, busy=0). The state is IDLE, r=0 and last_winner=decrypt.
- Reset mid-operation aborts with no done and no gnt. The first edge after reset deasserts may accept a request.
- Outputs are registered, or decoded from registered state only; none are combinational from inputs.

## Structure
- Shared package aes_pkg:
  - NR_128/192/256 constants
  - key_sel encodings
  - sequencer state enum
  - rk_idx width (4)
- Sub-module rr_arb2: two-requester round-robin arbiter holding last_winner. It updates only on an accept strobe from the sequencer FSM.

## Test plan
- key_sel=00, single enc_req: enc_gnt in the cycle after the request, rk_idx sequence 0,1..9,10, done 11 cycles after LOAD, dp_decrypt=0 throughout.
- key_sel=10, single dec_req: rk_idx sequence 14,13..1,0, dp_final while rk_idx=0, done 15 cycles after LOAD, nr=14.
- enc_req and dec_req both held continuously, key_sel=01: grants alternate enc, dec, enc, each op 13+1 cycles to done with one IDLE gap between ops.
- key_sel=11 with enc_req: err=1 every IDLE cycle, no gnt, busy=0. Switching to key_sel=00 gives acceptance on the next cycle.
- reset pulsed during the ROUND cycle with r=5 of a 192-bit op: all outputs 0 immediately, no done. A held dec_req is accepted again after reset release.
- key_sel toggled during a 128-bit op: nr stays 10 and the rk_idx sequence is unchanged.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared constants and types for the iterative AES round sequencer.
package aes_pkg;

    localparam int unsigned RK_W = 4;

    localparam int unsigned NR_128 = 10;
    localparam int unsigned NR_192 = 12;
    localparam int unsigned NR_256 = 14;

    localparam logic [1:0] KEY_SEL_128 = 2'b00;
    localparam logic [1:0] KEY_SEL_192 = 2'b01;
    localparam logic [1:0] KEY_SEL_256 = 2'b10;
    localparam logic [1:0] KEY_SEL_INV = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRound,
        StFinal,
        StDone
    } seq_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the last winner only moves on an accept strobe.
module rr_arb2 (
    input  logic clk_i,
    input  logic reset_i,
    input  logic req_enc_i,
    input  logic req_dec_i,
    input  logic accept_i,
    output logic win_dec_o
);

    // 1 = decrypt won last time; out of reset encrypt wins the first tie.
    logic last_dec_q;

    always_comb begin
        win_dec_o = req_dec_i && (!req_enc_i || !last_dec_q);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            last_dec_q <= 1'b1;
        end else if (accept_i) begin
            last_dec_q <= win_dec_o;
        end
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// Sequences the shared single-round AES datapath: load, nr-1 middle rounds, final, done.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int unsigned NR_128 = aes_pkg::NR_128,
    parameter int unsigned NR_192 = aes_pkg::NR_192,
    parameter int unsigned NR_256 = aes_pkg::NR_256
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            enc_req_i,
    input  logic            dec_req_i,
    input  logic [1:0]      key_sel_i,
    output logic            enc_gnt_o,
    output logic            dec_gnt_o,
    output logic            busy_o,
    output logic            dp_load_o,
    output logic            dp_round_o,
    output logic            dp_final_o,
    output logic            dp_decrypt_o,
    output logic [RK_W-1:0] rk_idx_o,
    output logic [RK_W-1:0] nr_o,
    output logic            done_o,
    output logic            err_o
);

    seq_state_e      state_q, state_d;
    logic [RK_W-1:0] r_q, r_d;
    logic [RK_W-1:0] nr_q, nr_d;
    logic            dec_q, dec_d;
    logic            err_q, err_d;
    logic [RK_W-1:0] nr_sel;
    logic            req, accept, win_dec;

    assign req = enc_req_i | dec_req_i;

    always_comb begin
        nr_sel = '0;
        unique case (key_sel_i)
            KEY_SEL_128: nr_sel = RK_W'(NR_128);
            KEY_SEL_192: nr_sel = RK_W'(NR_192);
            KEY_SEL_256: nr_sel = RK_W'(NR_256);
            default:     nr_sel = '0;
        endcase
    end

    rr_arb2 u_arb (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .req_enc_i (enc_req_i),
        .req_dec_i (dec_req_i),
        .accept_i  (accept),
        .win_dec_o (win_dec)
    );

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        nr_d    = nr_q;
        dec_d   = dec_q;
        err_d   = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                r_d = '0;
                if (req && key_sel_i != KEY_SEL_INV) begin
                    accept  = 1'b1;
                    state_d = StLoad;
                    nr_d    = nr_sel;
                    dec_d   = win_dec;
                end else if (req) begin
                    err_d = 1'b1;
                end
            end
            StLoad: begin
                r_d     = 4'd1;
                state_d = StRound;
            end
            StRound: begin
                // Hold r at nr-1 on the last middle round so it never exceeds 13.
                if (r_q == nr_q - 4'd1) begin
                    state_d = StFinal;
                end else begin
                    r_d = r_q + 4'd1;
                end
            end
            StFinal: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            r_q     <= '0;
            nr_q    <= '0;
            dec_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            nr_q    <= nr_d;
            dec_q   <= dec_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        rk_idx_o = '0;
        unique case (state_q)
            StLoad:          rk_idx_o = dec_q ? nr_q : '0;
            StRound:         rk_idx_o = dec_q ? nr_q - r_q : r_q;
            StFinal, StDone: rk_idx_o = dec_q ? '0 : nr_q;
            default:         rk_idx_o = '0;
        endcase
    end

    assign enc_gnt_o    = (state_q == StLoad) && !dec_q;
    assign dec_gnt_o    = (state_q == StLoad) && dec_q;
    assign dp_load_o    = (state_q == StLoad);
    assign dp_round_o   = (state_q == StRound);
    assign dp_final_o   = (state_q == StFinal);
    assign done_o       = (state_q == StDone);
    assign busy_o       = (state_q != StIdle);
    assign dp_decrypt_o = dec_q;
    assign nr_o         = nr_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed self-checking bench for aes_round_sequencer.
module tb_aes_round_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enc_req = 1'b0;
    logic       dec_req = 1'b0;
    logic [1:0] key_sel = 2'b00;
    logic       enc_gnt, dec_gnt, busy, dp_load, dp_round, dp_final, dp_decrypt, done, err;
    logic [3:0] rk_idx, nr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_round_sequencer dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .enc_req_i    (enc_req),
        .dec_req_i    (dec_req),
        .key_sel_i    (key_sel),
        .enc_gnt_o    (enc_gnt),
        .dec_gnt_o    (dec_gnt),
        .busy_o       (busy),
        .dp_load_o    (dp_load),
        .dp_round_o   (dp_round),
        .dp_final_o   (dp_final),
        .dp_decrypt_o (dp_decrypt),
        .rk_idx_o     (rk_idx),
        .nr_o         (nr),
        .done_o       (done),
        .err_o        (err)
    );

    // Flag vector order: enc_gnt dec_gnt load round final done busy err
    logic [7:0] flags;
    assign flags = {enc_gnt, dec_gnt, dp_load, dp_round, dp_final, done, busy, err};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts in the LOAD cycle, walks through DONE and ends in the following IDLE cycle.
    task automatic expect_op(input bit dec, input int n, input bit toggle);
        logic [3:0] n4;
        logic [7:0] exp_f;
        logic [8:0] exp_v;
        n4 = n[3:0];
        exp_f = {~dec, dec, 6'b100010};
        exp_v = {dec, n4, (dec ? n4 : 4'd0)};
        checks++;
        if (flags !== exp_f) begin
            errors++;
            $display("FAIL load_flags: got %b expected %b", flags, exp_f);
        end
        checks++;
        if ({dp_decrypt, nr, rk_idx} !== exp_v) begin
            errors++;
            $display("FAIL load_dir_nr_rk: got %b expected %b", {dp_decrypt, nr, rk_idx}, exp_v);
        end
        for (int i = 1; i < n; i++) begin
            tick();
            if (toggle) key_sel = key_sel + 2'd1;
            exp_v = {dec, n4, (dec ? n4 - i[3:0] : i[3:0])};
            checks++;
            if (flags !== 8'b0001_0010 || {dp_decrypt, nr, rk_idx} !== exp_v) begin
                errors++;
                $display("FAIL round_%0d: got %b/%b expected %b/%b", i, flags,
                         {dp_decrypt, nr, rk_idx}, 8'b0001_0010, exp_v);
            end
        end
        tick();
        exp_v = {dec, n4, (dec ? 4'd0 : n4)};
        checks++;
        if (flags !== 8'b0000_1010 || {dp_decrypt, nr, rk_idx} !== exp_v) begin
            errors++;
            $display("FAIL final: got %b/%b expected %b/%b", flags, {dp_decrypt, nr, rk_idx},
                     8'b0000_1010, exp_v);
        end
        tick();
        checks++;
        if (flags !== 8'b0000_0110 || {dp_decrypt, nr, rk_idx} !== exp_v) begin
            errors++;
            $display("FAIL done: got %b/%b expected %b/%b", flags, {dp_decrypt, nr, rk_idx},
                     8'b0000_0110, exp_v);
        end
        tick();
        checks++;
        if (flags !== 8'b0000_0000) begin
            errors++;
            $display("FAIL idle_after_done: got %b expected %b", flags, 8'b0);
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++;
        if ({flags, dp_decrypt, nr, rk_idx} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", {flags, dp_decrypt, nr, rk_idx},
                     17'd0);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (flags !== 8'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got %b expected %b", flags, 8'b0);
        end
    endtask

    task automatic test_enc128();
        key_sel = 2'b00;
        enc_req = 1'b1;
        tick();
        enc_req = 1'b0;
        expect_op(1'b0, 10, 1'b0);
    endtask

    task automatic test_dec256();
        key_sel = 2'b10;
        dec_req = 1'b1;
        tick();
        dec_req = 1'b0;
        expect_op(1'b1, 14, 1'b0);
    endtask

    task automatic test_back_to_back();
        key_sel = 2'b01;
        enc_req = 1'b1;
        dec_req = 1'b1;
        tick();
        expect_op(1'b0, 12, 1'b0);
        tick();
        expect_op(1'b1, 12, 1'b0);
        tick();
        enc_req = 1'b0;
        dec_req = 1'b0;
        expect_op(1'b0, 12, 1'b0);
    endtask

    task automatic test_err();
        key_sel = 2'b11;
        enc_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (flags !== 8'b0000_0001) begin
                errors++;
                $display("FAIL err_cycle_%0d: got %b expected %b", i, flags, 8'b0000_0001);
            end
        end
        key_sel = 2'b00;
        tick();
        enc_req = 1'b0;
        expect_op(1'b0, 10, 1'b0);
    endtask

    task automatic test_keysel_toggle();
        key_sel = 2'b00;
        enc_req = 1'b1;
        tick();
        enc_req = 1'b0;
        expect_op(1'b0, 10, 1'b1);
        key_sel = 2'b00;
    endtask

    task automatic test_reset_mid();
        key_sel = 2'b01;
        dec_req = 1'b1;
        tick();
        repeat (5) tick();
        checks++;
        if (flags !== 8'b0001_0010 || rk_idx !== 4'd7) begin
            errors++;
            $display("FAIL mid_round5: got %b/%0d expected %b/7", flags, rk_idx, 8'b0001_0010);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({flags, dp_decrypt, nr, rk_idx} !== 17'd0) begin
            errors++;
            $display("FAIL async_reset: got %b expected %b", {flags, dp_decrypt, nr, rk_idx},
                     17'd0);
        end
        tick();
        checks++;
        if (flags !== 8'b0) begin
            errors++;
            $display("FAIL held_reset: got %b expected %b", flags, 8'b0);
        end
        reset = 1'b0;
        tick();
        dec_req = 1'b0;
        expect_op(1'b1, 12, 1'b0);
    endtask

    initial begin
        test_reset();
        test_enc128();
        test_dec256();
        test_back_to_back();
        test_err();
        test_keysel_toggle();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
